// File: rtl/map_bram_arbiter.sv
// Single-port map BRAM arbiter: fixed-priority renderer with a starvation guard, round-robin r1/r2.
// Grant is combinational, the BRAM command is registered, read data returns RD_LAT+1 cycles after grant.
module map_bram_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    input  logic              r2_req,
    input  logic              r2_we,
    input  logic [ADDR_W-1:0] r2_addr,
    input  logic [DATA_W-1:0] r2_wdata,
    output logic              r2_gnt,
    output logic              r2_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic {
        RR_R1 = 1'b0,
        RR_R2 = 1'b1
    } rr_t;

    rr_t                    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0]      bram_addr_q, bram_addr_d;
    logic                   bram_we_q, bram_we_d;
    logic [DATA_W-1:0]      bram_wdata_q, bram_wdata_d;
    logic [RD_LAT:0]        tag_vld_q, tag_vld_d;
    logic [RD_LAT:0][1:0]   tag_id_q, tag_id_d;

    logic       pend12, guard, pick_r2;
    logic       gnt0, gnt1, gnt2;
    logic       issue_rd;
    logic [1:0] issue_id;

    always_comb begin
        pend12  = r1_req | r2_req;
        guard   = pend12 && (starve_cnt_q == CNT_MAX);
        pick_r2 = r2_req && (!r1_req || (rr_ptr_q == RR_R2));
        gnt0    = !sys_rst && r0_req && !guard;
        gnt1    = !sys_rst && !gnt0 && r1_req && !pick_r2;
        gnt2    = !sys_rst && !gnt0 && pick_r2;

        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        bram_addr_d  = bram_addr_q;
        bram_we_d    = 1'b0;
        bram_wdata_d = bram_wdata_q;
        issue_rd     = 1'b0;
        issue_id     = 2'd0;

        if (gnt0) begin
            bram_addr_d = r0_addr;
            issue_rd    = 1'b1;
            issue_id    = 2'd0;
        end else if (gnt1) begin
            bram_addr_d  = r1_addr;
            bram_we_d    = r1_we;
            bram_wdata_d = r1_wdata;
            issue_rd     = !r1_we;
            issue_id     = 2'd1;
            rr_ptr_d     = RR_R2;
        end else if (gnt2) begin
            bram_addr_d  = r2_addr;
            bram_we_d    = r2_we;
            bram_wdata_d = r2_wdata;
            issue_rd     = !r2_we;
            issue_id     = 2'd2;
            rr_ptr_d     = RR_R1;
        end

        // Counter only tracks renderer wins that made r1/r2 wait.
        if (gnt1 || gnt2 || !pend12) begin
            starve_cnt_d = '0;
        end else if (gnt0) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        tag_vld_d = {tag_vld_q[RD_LAT-1:0], issue_rd};
        tag_id_d  = {tag_id_q[RD_LAT-1:0], issue_id};
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            rr_ptr_q     <= RR_R1;
            starve_cnt_q <= '0;
            bram_addr_q  <= '0;
            bram_we_q    <= 1'b0;
            bram_wdata_q <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            bram_addr_q  <= bram_addr_d;
            bram_we_q    <= bram_we_d;
            bram_wdata_q <= bram_wdata_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
        end
    end

    assign r0_gnt     = gnt0;
    assign r1_gnt     = gnt1;
    assign r2_gnt     = gnt2;
    assign r0_rvalid  = tag_vld_q[RD_LAT] && (tag_id_q[RD_LAT] == 2'd0);
    assign r1_rvalid  = tag_vld_q[RD_LAT] && (tag_id_q[RD_LAT] == 2'd1);
    assign r2_rvalid  = tag_vld_q[RD_LAT] && (tag_id_q[RD_LAT] == 2'd2);
    assign rdata      = bram_rdata;
    assign bram_addr  = bram_addr_q;
    assign bram_we    = bram_we_q;
    assign bram_wdata = bram_wdata_q;

endmodule

// File: tb/tb_map_bram_arbiter.sv
// Directed bench for map_bram_arbiter: one instance at RD_LAT=1, one at RD_LAT=3.
// Unwritten BRAM words read back as addr[15:0] ^ 16'h5A5A.
module tb_map_bram_arbiter;

    logic        clk = 1'b0;
    logic        sys_rst;
    always #5 clk = ~clk;

    logic        r0_req, r1_req, r2_req, r1_we, r2_we;
    logic [18:0] r0_addr, r1_addr, r2_addr;
    logic [15:0] r1_wdata, r2_wdata;
    logic        r0_gnt, r1_gnt, r2_gnt, r0_rvalid, r1_rvalid, r2_rvalid;
    logic [15:0] rdata, bram_wdata, bram_rdata;
    logic [18:0] bram_addr;
    logic        bram_we;

    logic        b_r0_req, b_r1_req, b_r2_req, b_r1_we, b_r2_we;
    logic [18:0] b_r0_addr, b_r1_addr, b_r2_addr;
    logic [15:0] b_r1_wdata, b_r2_wdata;
    logic        b_r0_gnt, b_r1_gnt, b_r2_gnt, b_r0_rvalid, b_r1_rvalid, b_r2_rvalid;
    logic [15:0] b_rdata, b_bram_wdata, b_bram_rdata, rb1, rb2;
    logic [18:0] b_bram_addr;
    logic        b_bram_we;

    int checks = 0;
    int errors = 0;

    map_bram_arbiter #(.RD_LAT(1)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .r2_req(r2_req), .r2_we(r2_we), .r2_addr(r2_addr), .r2_wdata(r2_wdata),
        .r2_gnt(r2_gnt), .r2_rvalid(r2_rvalid),
        .rdata(rdata), .bram_addr(bram_addr), .bram_we(bram_we),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    map_bram_arbiter #(.RD_LAT(3)) dut_b (
        .clk(clk), .sys_rst(sys_rst),
        .r0_req(b_r0_req), .r0_addr(b_r0_addr), .r0_gnt(b_r0_gnt), .r0_rvalid(b_r0_rvalid),
        .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
        .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid),
        .r2_req(b_r2_req), .r2_we(b_r2_we), .r2_addr(b_r2_addr), .r2_wdata(b_r2_wdata),
        .r2_gnt(b_r2_gnt), .r2_rvalid(b_r2_rvalid),
        .rdata(b_rdata), .bram_addr(b_bram_addr), .bram_we(b_bram_we),
        .bram_wdata(b_bram_wdata), .bram_rdata(b_bram_rdata)
    );

    // One-cycle-latency BRAM model for the first instance.
    bit [15:0] mem_a [1024];
    bit        wr_a  [1024];
    always @(posedge clk) begin
        if (bram_we) begin
            mem_a[bram_addr[9:0]] <= bram_wdata;
            wr_a[bram_addr[9:0]]  <= 1'b1;
        end
        bram_rdata <= wr_a[bram_addr[9:0]] ? mem_a[bram_addr[9:0]] : (bram_addr[15:0] ^ 16'h5A5A);
    end

    // Three-cycle-latency read-only BRAM model for the second instance.
    always @(posedge clk) begin
        rb1          <= b_bram_addr[15:0] ^ 16'h5A5A;
        rb2          <= rb1;
        b_bram_rdata <= rb2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        sys_rst = 1'b1;
        r0_req = 1'b1; r1_req = 1'b1; r2_req = 1'b0; r1_we = 1'b0; r2_we = 1'b0;
        r0_addr = '0; r1_addr = '0; r2_addr = '0; r1_wdata = '0; r2_wdata = '0;
        b_r0_req = 1'b0; b_r1_req = 1'b0; b_r2_req = 1'b0; b_r1_we = 1'b0; b_r2_we = 1'b0;
        b_r0_addr = '0; b_r1_addr = '0; b_r2_addr = '0; b_r1_wdata = '0; b_r2_wdata = '0;

        // Reset state, with requests asserted during reset
        tick;
        chk("rst_r0_gnt", r0_gnt, 0);
        chk("rst_r1_gnt", r1_gnt, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_bram_we", bram_we, 0);
        chk("rst_bram_wdata", bram_wdata, 0);
        chk("rst_rvalid", {r0_rvalid, r1_rvalid, r2_rvalid}, 0);
        tick;
        sys_rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
        tick;

        // r1/r2 both pending: alternate starting with r1
        r1_addr = 19'h00001; r2_addr = 19'h00002;
        for (int i = 0; i < 8; i++) begin
            r1_req = (i < 6); r2_req = (i < 6);
            #1;
            chk("alt_r1_gnt", r1_gnt, (i < 6 && i % 2 == 0) ? 1 : 0);
            chk("alt_r2_gnt", r2_gnt, (i < 6 && i % 2 == 1) ? 1 : 0);
            if (i >= 2) begin
                chk("alt_r1_rvalid", r1_rvalid, (i % 2 == 0) ? 1 : 0);
                chk("alt_r2_rvalid", r2_rvalid, (i % 2 == 1) ? 1 : 0);
                chk("alt_rdata", rdata, (i % 2 == 0) ? 32'h5A5B : 32'h5A58);
            end else begin
                chk("alt_rvalid_early", {r0_rvalid, r1_rvalid, r2_rvalid}, 0);
            end
            tick;
        end

        // r2 writes 0xBEEF to 0x123, then r1 reads it back
        r2_req = 1'b1; r2_we = 1'b1; r2_addr = 19'h00123; r2_wdata = 16'hBEEF;
        #1;
        chk("wr_r2_gnt", r2_gnt, 1);
        tick;
        r2_req = 1'b0; r2_we = 1'b0;
        chk("wr_bram_we", bram_we, 1);
        chk("wr_bram_addr", bram_addr, 32'h00123);
        chk("wr_bram_wdata", bram_wdata, 32'hBEEF);
        tick;
        chk("wr_no_rvalid", {r0_rvalid, r1_rvalid, r2_rvalid}, 0);
        chk("idle_bram_we", bram_we, 0);
        chk("idle_bram_addr_hold", bram_addr, 32'h00123);

        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 19'h00123;
        #1;
        chk("rd_r1_gnt", r1_gnt, 1);
        tick;
        r1_req = 1'b0;
        chk("rd_bram_addr", bram_addr, 32'h00123);
        chk("rd_rvalid_t1", r1_rvalid, 0);
        tick;
        chk("rd_rvalid_t2", r1_rvalid, 1);
        chk("rd_rdata", rdata, 32'hBEEF);
        chk("rd_other_rvalid", {r0_rvalid, r2_rvalid}, 0);
        tick;
        chk("rd_rvalid_t3", r1_rvalid, 0);

        // Write followed immediately by a read of the same address
        r2_req = 1'b1; r2_we = 1'b1; r2_addr = 19'h00010; r2_wdata = 16'h00A5;
        #1;
        chk("raw_r2_gnt", r2_gnt, 1);
        tick;
        r2_req = 1'b0; r2_we = 1'b0;
        r1_req = 1'b1; r1_addr = 19'h00010;
        #1;
        chk("raw_r1_gnt", r1_gnt, 1);
        tick;
        r1_req = 1'b0;
        chk("raw_bram_addr", bram_addr, 32'h00010);
        chk("raw_write_no_rvalid", {r0_rvalid, r1_rvalid, r2_rvalid}, 0);
        tick;
        chk("raw_r1_rvalid", r1_rvalid, 1);
        chk("raw_rdata", rdata, 32'h00A5);
        chk("raw_r2_rvalid", r2_rvalid, 0);
        tick;

        // Starvation guard: 8 renderer grants, then r1, then renderer again
        r0_addr = 19'h00020; r1_addr = 19'h00030; r1_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            r0_req = 1'b1; r1_req = (i <= 8);
            #1;
            chk("stv_r0_gnt", r0_gnt, (i != 8) ? 1 : 0);
            chk("stv_r1_gnt", r1_gnt, (i == 8) ? 1 : 0);
            if (i >= 2) chk("stv_r0_rvalid", r0_rvalid, 1);
            tick;
        end
        r0_req = 1'b0;
        chk("stv_r1_rvalid", r1_rvalid, 1);
        chk("stv_r1_rdata", rdata, 32'h5A6A);
        tick;
        chk("stv_r0_rvalid_last", r0_rvalid, 1);
        chk("stv_r0_rdata_last", rdata, 32'h5A7A);
        chk("stv_r1_rvalid_off", r1_rvalid, 0);
        tick;

        // Renderer burst interrupted by reset on the third grant
        r0_req = 1'b1; r0_addr = 19'h00040;
        #1;
        chk("brst_gnt0", r0_gnt, 1);
        tick;
        r0_addr = 19'h00041;
        #1;
        chk("brst_gnt1", r0_gnt, 1);
        chk("brst_rvalid_early", r0_rvalid, 0);
        tick;
        r0_addr = 19'h00042; sys_rst = 1'b1;
        #1;
        chk("brst_gnt_in_rst", r0_gnt, 0);
        chk("brst_rvalid_pre_rst", r0_rvalid, 1);
        tick;
        chk("brst_rst_gnt", {r0_gnt, r1_gnt, r2_gnt}, 0);
        chk("brst_rst_rvalid", {r0_rvalid, r1_rvalid, r2_rvalid}, 0);
        chk("brst_rst_bram_addr", bram_addr, 0);
        chk("brst_rst_bram_we", bram_we, 0);
        chk("brst_rst_bram_wdata", bram_wdata, 0);
        tick;
        sys_rst = 1'b0; r0_req = 1'b0;
        chk("brst_post_rvalid0", {r0_rvalid, r1_rvalid, r2_rvalid}, 0);
        tick;
        chk("brst_post_rvalid1", {r0_rvalid, r1_rvalid, r2_rvalid}, 0);
        r1_req = 1'b1; r2_req = 1'b1; r1_we = 1'b0; r2_we = 1'b0;
        #1;
        chk("brst_rr_r1_gnt", r1_gnt, 1);
        chk("brst_rr_r2_gnt", r2_gnt, 0);
        tick;
        r1_req = 1'b0; r2_req = 1'b0;
        tick;
        tick;

        // RD_LAT=3 instance: alternating r0/r1 reads every cycle
        for (int i = 0; i < 12; i++) begin
            b_r0_req = (i < 8 && i % 2 == 0);
            b_r1_req = (i < 8 && i % 2 == 1);
            b_r0_addr = 19'(32'h50 + i);
            b_r1_addr = 19'(32'h50 + i);
            #1;
            chk("lat3_r0_gnt", b_r0_gnt, (i < 8 && i % 2 == 0) ? 1 : 0);
            chk("lat3_r1_gnt", b_r1_gnt, (i < 8 && i % 2 == 1) ? 1 : 0);
            if (i >= 4) begin
                chk("lat3_r0_rvalid", b_r0_rvalid, (i % 2 == 0) ? 1 : 0);
                chk("lat3_r1_rvalid", b_r1_rvalid, (i % 2 == 1) ? 1 : 0);
                chk("lat3_rdata", b_rdata, (32'h50 + i - 4) ^ 32'h5A5A);
            end else begin
                chk("lat3_rvalid_early", {b_r0_rvalid, b_r1_rvalid, b_r2_rvalid}, 0);
            end
            tick;
        end
        chk("lat3_bram_we", b_bram_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
